// File: rtl/multicycle_control_unit_if.sv
// Control-unit bundle: IR opcode, comparator flags, memory handshakes in; datapath controls out.
// Latency: none (wires only).
// Backpressure: imem_ready/dmem_ready are the only stall inputs; the control unit owns the master modport.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                equal;
  logic                less;
  logic                greater;
  logic                imem_ready;
  logic                dmem_ready;
  logic                PC_WE;
  logic                IR_WE;
  logic                regWrite;
  logic                immSignal;
  logic                jump;
  logic                memLoad;
  logic                memSt;
  logic                memAlu;
  logic                branchMux;
  logic                branchSig;
  logic [1:0]          aluControl;
  logic                illegal;
  logic [CNT_W-1:0]    instr_retired;

  modport master (
    input  opcode, equal, less, greater, imem_ready, dmem_ready,
    output PC_WE, IR_WE, regWrite, immSignal, jump, memLoad, memSt, memAlu,
           branchMux, branchSig, aluControl, illegal, instr_retired
  );

  modport slave (
    output opcode, equal, less, greater, imem_ready, dmem_ready,
    input  PC_WE, IR_WE, regWrite, immSignal, jump, memLoad, memSt, memAlu,
           branchMux, branchSig, aluControl, illegal, instr_retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer driving datapath controls.
// Latency: ALU 4, jump/branch 3, LD 5, ST 4 cycles with zero-wait memories; controls combinational from state_q/op_q.
// Backpressure: holds in FETCH while imem_ready=0 and in MEM while dmem_ready=0; CU_ILLEGAL_TRAP_EN traps codes >= 16.
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 16
) (
  input logic                       clock,
  input logic                       reset,
  multicycle_control_unit_if.master cu_io
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Opcode classification; anything with bits above [3:0] set is illegal.
  logic [3:0] op_lo;
  logic       op_hi;
  logic       is_alu, is_jmp, is_ld, is_st, is_br;

  assign op_lo = op_q[3:0];

  if (OPCODE_W > 4) begin : g_wide_op
    assign op_hi = |op_q[OPCODE_W-1:4];
  end else begin : g_narrow_op
    assign op_hi = 1'b0;
  end

  assign is_alu = ~op_hi & ~op_lo[3];
  assign is_jmp = ~op_hi & (op_lo == 4'h8);
  assign is_ld  = ~op_hi & (op_lo == 4'h9);
  assign is_st  = ~op_hi & (op_lo == 4'hA);
  assign is_br  = ~op_hi & (op_lo >= 4'hB);

  // Raw controls before reset gating.
  logic       pc_we, ir_we, reg_write, imm_sig, jump, mem_load, mem_st, mem_alu;
  logic       branch_mux, branch_sig, illegal;
  logic [1:0] alu_ctl;

  // Next-state and control decode from the current state and latched opcode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_write  = 1'b0;
    imm_sig    = 1'b0;
    jump       = 1'b0;
    mem_load   = 1'b0;
    mem_st     = 1'b0;
    mem_alu    = 1'b0;
    branch_mux = 1'b0;
    branch_sig = 1'b0;
    illegal    = 1'b0;
    alu_ctl    = 2'b00;

    case (state_q)
      S_FETCH: begin
        if (cu_io.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        op_d    = cu_io.opcode;
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        if (is_alu) begin
          alu_ctl = op_lo[2:1];
          imm_sig = op_lo[0];
          state_d = S_WRITEBACK;
        end else if (is_jmp) begin
          jump    = 1'b1;
          pc_we   = 1'b1;
          state_d = S_FETCH;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_br) begin
          branch_mux = 1'b1;
          pc_we      = 1'b1;
          // Flags are only looked at here, so later flag changes cannot alter the branch.
          case (op_lo)
            4'hB:    branch_sig = cu_io.equal;
            4'hC:    branch_sig = cu_io.less;
            4'hD:    branch_sig = cu_io.greater;
            4'hE:    branch_sig = cu_io.equal | cu_io.less;
            4'hF:    branch_sig = cu_io.equal | cu_io.greater;
            default: branch_sig = 1'b0;
          endcase
          state_d = S_FETCH;
        end else begin
`ifdef CU_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          // Illegal code retires as a NOP.
          pc_we   = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end

      S_MEM: begin
        mem_alu  = 1'b1;
        mem_load = is_ld;
        mem_st   = is_st;
        if (cu_io.dmem_ready) begin
          if (is_ld) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        if (is_alu) begin
          alu_ctl = op_lo[2:1];
          imm_sig = op_lo[0];
        end
        if (is_ld) begin
          mem_load = 1'b1;
          mem_alu  = 1'b1;
        end
        state_d = S_FETCH;
      end

      S_TRAP: begin
`ifdef CU_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every output low in the same cycle, so an abandoned instruction never writes PC or RF.
  logic pc_we_g;
  assign pc_we_g = pc_we & ~reset;

  assign cu_io.PC_WE         = pc_we_g;
  assign cu_io.IR_WE         = ir_we      & ~reset;
  assign cu_io.regWrite      = reg_write  & ~reset;
  assign cu_io.immSignal     = imm_sig    & ~reset;
  assign cu_io.jump          = jump       & ~reset;
  assign cu_io.memLoad       = mem_load   & ~reset;
  assign cu_io.memSt         = mem_st     & ~reset;
  assign cu_io.memAlu        = mem_alu    & ~reset;
  assign cu_io.branchMux     = branch_mux & ~reset;
  assign cu_io.branchSig     = branch_sig & ~reset;
  assign cu_io.aluControl    = reset ? 2'b00 : alu_ctl;
  assign cu_io.illegal       = illegal    & ~reset;
  assign cu_io.instr_retired = reset ? '0 : cnt_q;

  // Retired-instruction count: one per PC write, wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (pc_we_g) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, opcode latch and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default instance plus an OPCODE_W=5/CNT_W=2 instance.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Control vector order: {PC_WE, IR_WE, regWrite, immSignal, jump, memLoad, memSt, memAlu, branchMux, branchSig, aluControl}.
module tb_multicycle_control_unit;

  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clock = ~clock;

  multicycle_control_unit_if #(.OPCODE_W(4), .CNT_W(16)) bus_a ();
  multicycle_control_unit_if #(.OPCODE_W(5), .CNT_W(2))  bus_b ();

  multicycle_control_unit #(.OPCODE_W(4), .CNT_W(16)) dut_a (
    .clock (clock),
    .reset (reset_a),
    .cu_io (bus_a.master)
  );

  multicycle_control_unit #(.OPCODE_W(5), .CNT_W(2)) dut_b (
    .clock (clock),
    .reset (reset_b),
    .cu_io (bus_b.master)
  );

  localparam logic [11:0] C_P   = 12'h800;
  localparam logic [11:0] C_I   = 12'h400;
  localparam logic [11:0] C_RW  = 12'h200;
  localparam logic [11:0] C_IMM = 12'h100;
  localparam logic [11:0] C_J   = 12'h080;
  localparam logic [11:0] C_ML  = 12'h040;
  localparam logic [11:0] C_MS  = 12'h020;
  localparam logic [11:0] C_MA  = 12'h010;
  localparam logic [11:0] C_BM  = 12'h008;
  localparam logic [11:0] C_BS  = 12'h004;

  int checks  = 0;
  int errors  = 0;
  int exp_cnt = 0;

  function automatic logic [11:0] ctl_a();
    return {bus_a.PC_WE, bus_a.IR_WE, bus_a.regWrite, bus_a.immSignal, bus_a.jump,
            bus_a.memLoad, bus_a.memSt, bus_a.memAlu, bus_a.branchMux, bus_a.branchSig,
            bus_a.aluControl};
  endfunction

  function automatic logic [11:0] ctl_b();
    return {bus_b.PC_WE, bus_b.IR_WE, bus_b.regWrite, bus_b.immSignal, bus_b.jump,
            bus_b.memLoad, bus_b.memSt, bus_b.memAlu, bus_b.branchMux, bus_b.branchSig,
            bus_b.aluControl};
  endfunction

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_a();
    bus_a.opcode = 4'h0; bus_a.equal = 1'b0; bus_a.less = 1'b0; bus_a.greater = 1'b0;
    bus_a.imem_ready = 1'b0; bus_a.dmem_ready = 1'b0;
  endtask

  task automatic clear_b();
    bus_b.opcode = 5'h00; bus_b.equal = 1'b0; bus_b.less = 1'b0; bus_b.greater = 1'b0;
    bus_b.imem_ready = 1'b0; bus_b.dmem_ready = 1'b0;
  endtask

  task automatic reset_seq_a();
    reset_a = 1'b1; clear_a(); adv(); adv(); reset_a = 1'b0; exp_cnt = 0;
  endtask

  task automatic reset_seq_b();
    reset_b = 1'b1; clear_b(); adv(); adv(); reset_b = 1'b0;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.opcode = 4'h1; bus_a.equal = 1'b1; bus_a.less = 1'b1; bus_a.greater = 1'b1;
    bus_a.imem_ready = 1'b1; bus_a.dmem_ready = 1'b1;
    bus_b.opcode = 5'h12; bus_b.equal = 1'b1; bus_b.less = 1'b1; bus_b.greater = 1'b1;
    bus_b.imem_ready = 1'b1; bus_b.dmem_ready = 1'b1;
    adv(); adv();
    @(negedge clock);
    checks++; if (ctl_a() !== 12'h000) begin errors++; $display("FAIL reset_ctl_a got=%h want=000", ctl_a()); end
    checks++; if (bus_a.instr_retired !== 16'd0) begin errors++; $display("FAIL reset_cnt_a got=%0d want=0", bus_a.instr_retired); end
    checks++; if (bus_a.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal_a got=%b want=0", bus_a.illegal); end
    checks++; if (ctl_b() !== 12'h000) begin errors++; $display("FAIL reset_ctl_b got=%h want=000", ctl_b()); end
    clear_a(); clear_b();
    reset_a = 1'b0; reset_b = 1'b0; exp_cnt = 0;
    adv();
    @(negedge clock);
    checks++; if (ctl_a() !== 12'h000) begin errors++; $display("FAIL reset_idle_fetch got=%h want=000", ctl_a()); end
  endtask

  task automatic test_addi();
    logic [11:0] exp [4];
    exp[0] = C_I; exp[1] = 12'h000; exp[2] = C_IMM; exp[3] = C_IMM | C_RW | C_P;
    adv();
    bus_a.opcode = 4'h1;
    for (int c = 0; c < 4; c++) begin
      bus_a.imem_ready = (c == 0);
      @(negedge clock);
      checks++;
      if (ctl_a() !== exp[c]) begin errors++; $display("FAIL addi cyc=%0d got=%h want=%h", c + 1, ctl_a(), exp[c]); end
      adv();
    end
    exp_cnt++;
    bus_a.imem_ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.instr_retired !== 16'd1) begin errors++; $display("FAIL addi_cnt got=%0d want=1", bus_a.instr_retired); end
  endtask

  task automatic test_alu_ops();
    logic [1:0]  alu_tab [8];
    logic        imm_tab [8];
    logic [11:0] exp [4];
    alu_tab = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
    imm_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    adv();
    for (int op = 0; op < 8; op++) begin
      exp[0] = C_I;
      exp[1] = 12'h000;
      exp[2] = {10'd0, alu_tab[op]} | (imm_tab[op] ? C_IMM : 12'h000);
      exp[3] = exp[2] | C_RW | C_P;
      bus_a.opcode = 4'(op);
      for (int c = 0; c < 4; c++) begin
        bus_a.imem_ready = (c == 0);
        @(negedge clock);
        checks++;
        if (ctl_a() !== exp[c]) begin errors++; $display("FAIL alu op=%0h cyc=%0d got=%h want=%h", op, c + 1, ctl_a(), exp[c]); end
        adv();
      end
      exp_cnt++;
    end
    bus_a.imem_ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.instr_retired !== 16'(exp_cnt)) begin errors++; $display("FAIL alu_cnt got=%0d want=%0d", bus_a.instr_retired, exp_cnt); end
  endtask

  task automatic test_fetch_stall();
    logic [11:0] exp [5];
    logic        im  [5];
    exp = '{12'h000, 12'h000, C_I, 12'h000, C_J | C_P};
    im  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    adv();
    bus_a.opcode = 4'h8;
    bus_a.dmem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus_a.imem_ready = im[c];
      @(negedge clock);
      checks++;
      if (ctl_a() !== exp[c]) begin errors++; $display("FAIL fetch_stall cyc=%0d got=%h want=%h", c + 1, ctl_a(), exp[c]); end
      adv();
    end
    exp_cnt++;
    bus_a.imem_ready = 1'b0; bus_a.dmem_ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.instr_retired !== 16'(exp_cnt)) begin errors++; $display("FAIL fetch_stall_cnt got=%0d want=%0d", bus_a.instr_retired, exp_cnt); end
  endtask

  task automatic test_load_stall();
    logic [11:0] exp [8];
    logic        im  [8];
    logic        dm  [8];
    exp = '{C_I, 12'h000, 12'h000, C_ML | C_MA, C_ML | C_MA, C_ML | C_MA, C_ML | C_MA,
            C_RW | C_P | C_ML | C_MA};
    im  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dm  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    adv();
    bus_a.opcode = 4'h9;
    for (int c = 0; c < 8; c++) begin
      bus_a.imem_ready = im[c];
      bus_a.dmem_ready = dm[c];
      @(negedge clock);
      checks++;
      if (ctl_a() !== exp[c]) begin errors++; $display("FAIL load_stall cyc=%0d got=%h want=%h", c + 1, ctl_a(), exp[c]); end
      adv();
    end
    exp_cnt++;
    bus_a.imem_ready = 1'b0; bus_a.dmem_ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.instr_retired !== 16'(exp_cnt)) begin errors++; $display("FAIL load_cnt got=%0d want=%0d", bus_a.instr_retired, exp_cnt); end
  endtask

  task automatic test_store_stall();
    logic [11:0] exp [7];
    logic        dm  [7];
    exp = '{C_I, 12'h000, 12'h000, C_MS | C_MA, C_MS | C_MA, C_MS | C_MA, C_MS | C_MA | C_P};
    dm  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    adv();
    bus_a.opcode = 4'hA;
    for (int c = 0; c < 7; c++) begin
      bus_a.imem_ready = (c == 0);
      bus_a.dmem_ready = dm[c];
      @(negedge clock);
      checks++;
      if (ctl_a() !== exp[c]) begin errors++; $display("FAIL store_stall cyc=%0d got=%h want=%h", c + 1, ctl_a(), exp[c]); end
      adv();
    end
    exp_cnt++;
    bus_a.imem_ready = 1'b0; bus_a.dmem_ready = 1'b0;
    @(negedge clock);
    checks++; if (bus_a.instr_retired !== 16'(exp_cnt)) begin errors++; $display("FAIL store_cnt got=%0d want=%0d", bus_a.instr_retired, exp_cnt); end
  endtask

  task automatic test_branches();
    // Per opcode B..F: bit0 = result with equal only, bit1 = less only, bit2 = greater only.
    logic [2:0]  bs_tab [5];
    logic [11:0] exp [3];
    bs_tab = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101};
    adv();
    for (int b = 0; b < 5; b++) begin
      for (int f = 0; f < 3; f++) begin
        bus_a.opcode  = 4'(11 + b);
        bus_a.equal   = (f == 0);
        bus_a.less    = (f == 1);
        bus_a.greater = (f == 2);
        exp[0] = C_I;
        exp[1] = 12'h000;
        exp[2] = C_BM | C_P | (bs_tab[b][f] ? C_BS : 12'h000);
        for (int c = 0; c < 3; c++) begin
          bus_a.imem_ready = (c == 0);
          @(negedge clock);
          checks++;
          if (ctl_a() !== exp[c]) begin errors++; $display("FAIL branch op=%0h flag=%0d cyc=%0d got=%h want=%h", 11 + b, f, c + 1, ctl_a(), exp[c]); end
          adv();
        end
        exp_cnt++;
      end
    end
    bus_a.imem_ready = 1'b0;
    @(negedge clock);
    checks++; if (ctl_a() !== 12'h000) begin errors++; $display("FAIL branch_flags_after got=%h want=000", ctl_a()); end
    checks++; if (bus_a.instr_retired !== 16'(exp_cnt)) begin errors++; $display("FAIL branch_cnt got=%0d want=%0d", bus_a.instr_retired, exp_cnt); end
    bus_a.equal = 1'b0; bus_a.less = 1'b0; bus_a.greater = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    logic [11:0] exp [4];
    exp = '{C_I, 12'h000, 12'h000, C_MS | C_MA};
    adv();
    bus_a.opcode = 4'hA;
    for (int c = 0; c < 4; c++) begin
      bus_a.imem_ready = (c == 0);
      bus_a.dmem_ready = 1'b0;
      @(negedge clock);
      checks++;
      if (ctl_a() !== exp[c]) begin errors++; $display("FAIL rst_store cyc=%0d got=%h want=%h", c + 1, ctl_a(), exp[c]); end
      adv();
    end
    reset_a = 1'b1;
    bus_a.dmem_ready = 1'b1;
    @(negedge clock);
    checks++; if (ctl_a() !== 12'h000) begin errors++; $display("FAIL rst_store_during got=%h want=000", ctl_a()); end
    checks++; if (bus_a.instr_retired !== 16'd0) begin errors++; $display("FAIL rst_store_cnt_during got=%0d want=0", bus_a.instr_retired); end
    adv();
    reset_a = 1'b0; exp_cnt = 0;
    bus_a.dmem_ready = 1'b1;
    @(negedge clock);
    checks++; if (ctl_a() !== 12'h000) begin errors++; $display("FAIL rst_store_after got=%h want=000", ctl_a()); end
    checks++; if (bus_a.instr_retired !== 16'd0) begin errors++; $display("FAIL rst_store_cnt_after got=%0d want=0", bus_a.instr_retired); end
    adv();
    bus_a.dmem_ready = 1'b0;
    bus_a.imem_ready = 1'b1;
    @(negedge clock);
    checks++; if (ctl_a() !== C_I) begin errors++; $display("FAIL rst_store_fetch got=%h want=%h", ctl_a(), C_I); end
    reset_seq_a();
  endtask

  task automatic test_illegal();
    reset_seq_b();
    bus_b.opcode = 5'h12;
`ifdef CU_ILLEGAL_TRAP_EN
    for (int c = 0; c < 7; c++) begin
      bus_b.imem_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (ctl_b() !== ((c == 0) ? C_I : 12'h000)) begin errors++; $display("FAIL trap cyc=%0d got=%h want=%h", c + 1, ctl_b(), (c == 0) ? C_I : 12'h000); end
      checks++;
      if (bus_b.illegal !== (c >= 3)) begin errors++; $display("FAIL trap_illegal cyc=%0d got=%b want=%b", c + 1, bus_b.illegal, c >= 3); end
      adv();
    end
    checks++; if (bus_b.instr_retired !== 2'd0) begin errors++; $display("FAIL trap_cnt got=%0d want=0", bus_b.instr_retired); end
    reset_seq_b();
    @(negedge clock);
    checks++; if (bus_b.illegal !== 1'b0) begin errors++; $display("FAIL trap_clear got=%b want=0", bus_b.illegal); end
`else
    begin
      logic [11:0] exp [3];
      exp = '{C_I, 12'h000, C_P};
      for (int c = 0; c < 3; c++) begin
        bus_b.imem_ready = (c == 0);
        @(negedge clock);
        checks++;
        if (ctl_b() !== exp[c]) begin errors++; $display("FAIL nop cyc=%0d got=%h want=%h", c + 1, ctl_b(), exp[c]); end
        checks++;
        if (bus_b.illegal !== 1'b0) begin errors++; $display("FAIL nop_illegal cyc=%0d got=%b want=0", c + 1, bus_b.illegal); end
        adv();
      end
      bus_b.imem_ready = 1'b0;
      @(negedge clock);
      checks++; if (bus_b.instr_retired !== 2'd1) begin errors++; $display("FAIL nop_cnt got=%0d want=1", bus_b.instr_retired); end
    end
`endif
  endtask

  task automatic test_counter_wrap();
    logic [1:0] wrap_tab [5];
    wrap_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    reset_seq_b();
    bus_b.opcode = 5'h08;
    for (int j = 0; j < 5; j++) begin
      for (int c = 0; c < 3; c++) begin
        bus_b.imem_ready = (c == 0);
        adv();
      end
      bus_b.imem_ready = 1'b0;
      @(negedge clock);
      checks++;
      if (bus_b.instr_retired !== wrap_tab[j]) begin errors++; $display("FAIL wrap jump=%0d got=%0d want=%0d", j + 1, bus_b.instr_retired, wrap_tab[j]); end
      adv();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    clear_a();
    clear_b();
    test_reset();
    test_addi();
    test_alu_ops();
    test_fetch_stall();
    test_load_stall();
    test_store_stall();
    test_branches();
    test_reset_mid_store();
    test_illegal();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
